// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST inference layers.
// Holds the fully-connected layer state encoding, the default fixed-point
// format and the shift/ReLU/saturate helper used by every MAC lane.
package nn_pkg;

    localparam int unsigned NN_DATA_W = 16;
    localparam int unsigned NN_FRAC   = 8;
    // Working width for sat_fx; must cover the widest accumulator in use.
    localparam int unsigned SAT_W     = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIAS,
        ST_MAC,
        ST_ACT,
        ST_OUT,
        ST_DONE
    } fc_state_t;

    // Rescale an accumulator by frac bits, optionally clamp negatives to zero,
    // then saturate into a signed data_w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_fx(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             frac,
        input int unsigned             data_w,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        r  = acc >>> frac;
        if (relu && r[SAT_W-1]) begin
            r = '0;
        end
        hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron of the fully-connected layer.
// Ports: Clk/Rst_n clock and async active-low reset; init loads the bias beat,
// acc_en adds x*w, act_en registers the activated result; relu selects ReLU;
// x activation, w weight or bias; res registered result, res_c its next value.
module fc_mac_lane
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned FRAC   = NN_FRAC,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     init,
    input  logic                     acc_en,
    input  logic                     act_en,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [DATA_W-1:0] res,
    output logic signed [DATA_W-1:0] res_c
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SAT_W-1:0]    sat;

    assign prod  = x * w;
    assign sat   = sat_fx(SAT_W'(acc), FRAC, DATA_W, relu);
    assign res_c = DATA_W'(sat);

    // Bias is aligned to the product scale (2*FRAC fraction bits) on load.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (init) begin
                acc <= ACC_W'(w) <<< FRAC;
            end else if (acc_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (act_en) begin
                res <= res_c;
            end
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: buffers an N_IN input vector, streams weight rows
// from an external ROM into N_OUT parallel MAC lanes, then emits N_OUT
// activations with an in-stream argmax.
// Ports: Clk/Rst_n; relu_en; in_valid/in_ready/in_data input stream;
// w_rd/w_addr/w_data weight ROM (row N_IN holds biases); out_valid/out_ready/
// out_data/out_idx/out_last output stream; pred/pred_valid argmax; busy.
module fc_layer_engine
    import nn_pkg::*;
#(
    parameter int unsigned N_IN   = 784,
    parameter int unsigned N_OUT  = 30,
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned FRAC   = NN_FRAC,
    parameter int unsigned ACC_W  = 48,
    parameter int unsigned AW     = $clog2(N_IN + 1),
    localparam int unsigned OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    w_rd,
    output logic [AW-1:0]           w_addr,
    input  logic [N_OUT*DATA_W-1:0] w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [OW-1:0]           out_idx,
    output logic                    out_last,
    output logic [OW-1:0]           pred,
    output logic                    pred_valid,
    output logic                    busy
);

    localparam int unsigned IBW = (N_IN > 1) ? $clog2(N_IN) : 1;

    if (ACC_W < 2 * DATA_W + $clog2(N_IN + 1)) begin : g_acc_w_check
        $error("fc_layer_engine: ACC_W too narrow for N_IN and DATA_W");
    end

    fc_state_t                state;
    logic [AW-1:0]            in_cnt;
    logic [AW-1:0]            mac_cnt;
    logic signed [DATA_W-1:0] xbuf [N_IN];
    logic                     relu_q;
    logic signed [DATA_W-1:0] res   [N_OUT];
    logic signed [DATA_W-1:0] res_c [N_OUT];
    logic signed [DATA_W-1:0] best_val;
    logic [OW-1:0]            best_idx;
    logic signed [DATA_W-1:0] arg_val;
    logic [OW-1:0]            arg_idx;
    logic                     lane_init;
    logic                     lane_acc;
    logic                     lane_act;
    logic signed [DATA_W-1:0] x_sel;

    // MAC count 0 is the bias beat; count k>0 carries row k-1.
    assign lane_init = (state == ST_MAC) && (mac_cnt == '0);
    assign lane_acc  = (state == ST_MAC) && (mac_cnt != '0);
    assign lane_act  = (state == ST_ACT);

    always_comb begin
        x_sel = '0;
        if (mac_cnt != '0) begin
            x_sel = xbuf[IBW'(mac_cnt - AW'(1))];
        end
    end

    // Argmax including the current beat; strict > keeps the lower index on ties.
    always_comb begin
        arg_val = best_val;
        arg_idx = best_idx;
        if (out_idx == '0 || $signed(out_data) > best_val) begin
            arg_val = out_data;
            arg_idx = out_idx;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        fc_mac_lane #(
            .DATA_W(DATA_W),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .init  (lane_init),
            .acc_en(lane_acc),
            .act_en(lane_act),
            .relu  (relu_q),
            .x     (x_sel),
            .w     (w_data[j*DATA_W +: DATA_W]),
            .res   (res[j]),
            .res_c (res_c[j])
        );
    end

    // Control FSM with registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            w_rd       <= 1'b0;
            w_addr     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            pred       <= '0;
            pred_valid <= 1'b0;
            busy       <= 1'b0;
            in_cnt     <= '0;
            mac_cnt    <= '0;
            relu_q     <= 1'b0;
            best_val   <= '0;
            best_idx   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                xbuf[i] <= '0;
            end
        end else begin
            pred_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        xbuf[0] <= in_data;
                        relu_q  <= relu_en;
                        busy    <= 1'b1;
                        in_cnt  <= AW'(1);
                        if (N_IN == 1) begin
                            state    <= ST_BIAS;
                            in_ready <= 1'b0;
                            w_rd     <= 1'b1;
                            w_addr   <= AW'(N_IN);
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        xbuf[IBW'(in_cnt)] <= in_data;
                        in_cnt             <= in_cnt + AW'(1);
                        if (in_cnt == AW'(N_IN - 1)) begin
                            state    <= ST_BIAS;
                            in_ready <= 1'b0;
                            w_rd     <= 1'b1;
                            w_addr   <= AW'(N_IN);
                        end
                    end
                end
                ST_BIAS: begin
                    state   <= ST_MAC;
                    mac_cnt <= '0;
                    w_rd    <= 1'b1;
                    w_addr  <= '0;
                end
                ST_MAC: begin
                    mac_cnt <= mac_cnt + AW'(1);
                    if (mac_cnt < AW'(N_IN - 1)) begin
                        w_rd   <= 1'b1;
                        w_addr <= mac_cnt + AW'(1);
                    end else begin
                        w_rd   <= 1'b0;
                        w_addr <= '0;
                    end
                    if (mac_cnt == AW'(N_IN)) begin
                        state <= ST_ACT;
                    end
                end
                ST_ACT: begin
                    // Lane results register on this edge, so beat 0 takes the lane's next value.
                    state     <= ST_OUT;
                    out_valid <= 1'b1;
                    out_idx   <= '0;
                    out_data  <= res_c[0];
                    out_last  <= (N_OUT == 1);
                end
                ST_OUT: begin
                    if (out_ready) begin
                        best_val <= arg_val;
                        best_idx <= arg_idx;
                        if (out_last) begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            pred       <= arg_idx;
                            pred_valid <= 1'b1;
                        end else begin
                            out_idx  <= out_idx + OW'(1);
                            out_data <= res[out_idx + OW'(1)];
                            out_last <= ((out_idx + OW'(1)) == OW'(N_OUT - 1));
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    in_cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine with N_IN=4, N_OUT=3, Q8.8 data.
// The bench models the weight ROM (one-cycle read latency) and checks
// outputs, handshakes, latency, address order and reset behaviour.
module tb_fc_layer_engine;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned N_OUT  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AW     = 3;
    localparam int unsigned OW     = 2;

    logic                    Clk = 1'b0;
    logic                    Rst_n = 1'b0;
    logic                    relu_en = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    w_rd;
    logic [AW-1:0]           w_addr;
    logic [N_OUT*DATA_W-1:0] w_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DATA_W-1:0]       out_data;
    logic [OW-1:0]           out_idx;
    logic                    out_last;
    logic [OW-1:0]           pred;
    logic                    pred_valid;
    logic                    busy;

    fc_layer_engine #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .DATA_W(DATA_W),
        .FRAC  (8),
        .ACC_W (48),
        .AW    (AW)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_rd      (w_rd),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .pred      (pred),
        .pred_valid(pred_valid),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Weight ROM: rows 0..3 weights, row 4 biases; lane j at [j*16 +: 16].
    logic [N_OUT*DATA_W-1:0] rom [0:4];
    always @(posedge Clk) if (w_rd) w_data <= rom[w_addr];

    int          checks = 0;
    int          errors = 0;
    int          hs_cyc = 0;
    logic [15:0] xv [4];
    int          gap [4];
    logic        rdy_pat [4];
    logic [15:0] exp_out [3];
    logic [1:0]  exp_pred;
    bit          chk_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_test1();
        rom[0] = {16'hFF00, 16'h0000, 16'h0100};
        rom[1] = {16'h0000, 16'h0080, 16'h0000};
        rom[2] = '0;
        rom[3] = '0;
        rom[4] = {16'h0000, 16'h0040, 16'h0000};
        xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'h0000; xv[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            gap[i]     = 0;
            rdy_pat[i] = 1'b1;
        end
    endtask

    // Drive the four input words; relu_en is flipped after word 0 to prove it is latched.
    task automatic feed(input string tag, input logic relu);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            repeat (gap[i]) @(negedge Clk);
            in_valid = 1'b1;
            in_data  = xv[i];
            if (i == 0) relu_en = relu;
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            @(negedge Clk);
            if (i == 0) relu_en = ~relu;
        end
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        hs_cyc   = cyc;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic collect(input string tag);
        logic [AW-1:0] addrs [8];
        int n_rd  = 0;
        int first = 0;
        int beat  = 0;
        int p     = 0;
        bit got   = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (out_valid) begin
                got   = 1;
                first = cyc;
            end else begin
                if (w_rd && n_rd < 8) begin
                    addrs[n_rd] = w_addr;
                    n_rd++;
                end
                @(negedge Clk);
            end
        end
        chk({tag, "_ov_seen"}, 32'(got), 32'd1);
        if (chk_lat) begin
            chk({tag, "_ov_latency"}, 32'(first + 1 - hs_cyc), 32'(N_IN + 4));
            chk({tag, "_n_reads"}, 32'(n_rd), 32'd5);
            chk({tag, "_addr_bias"}, 32'(addrs[0]), 32'(N_IN));
            for (int k = 1; k < 5; k++) chk({tag, "_addr_row"}, 32'(addrs[k]), 32'(k - 1));
        end
        for (int t = 0; t < 60 && beat < 3; t++) begin
            out_ready = rdy_pat[p % 4];
            p++;
            chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_out_idx"}, 32'(out_idx), 32'(beat));
            chk({tag, "_out_data"}, 32'(out_data), 32'(exp_out[beat]));
            chk({tag, "_out_last"}, 32'(out_last), 32'(beat == 2));
            if (out_ready && out_valid) beat++;
            @(negedge Clk);
        end
        out_ready = 1'b0;
        chk({tag, "_beats"}, 32'(beat), 32'd3);
        chk({tag, "_pred_valid"}, 32'(pred_valid), 32'd1);
        chk({tag, "_pred"}, 32'(pred), 32'(exp_pred));
        if (chk_lat) chk({tag, "_pred_latency"}, 32'(cyc + 1 - hs_cyc), 32'(N_IN + 4 + N_OUT));
        @(negedge Clk);
        chk({tag, "_pred_pulse"}, 32'(pred_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_pred_hold"}, 32'(pred), 32'(exp_pred));
    endtask

    task automatic run_vector(input string tag, input logic relu);
        feed(tag, relu);
        collect(tag);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_w_rd", 32'(w_rd), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred", 32'(pred), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Basic run with ReLU, plus latency and address order.
        load_test1();
        exp_out[0] = 16'h0100; exp_out[1] = 16'h0140; exp_out[2] = 16'h0000;
        exp_pred = 2'd1;
        chk_lat  = 1;
        run_vector("relu_on", 1'b1);

        // Same stimulus without ReLU: lane 2 keeps -1.0.
        chk_lat    = 0;
        exp_out[2] = 16'hFF00;
        run_vector("relu_off", 1'b0);

        // Saturation to both rails.
        for (int r = 0; r < 4; r++) begin
            rom[r] = {16'h0000, 16'hFF00, 16'h0100};
            xv[r]  = 16'h7F00;
        end
        rom[4] = '0;
        exp_out[0] = 16'h7FFF; exp_out[1] = 16'h8000; exp_out[2] = 16'h0000;
        exp_pred = 2'd0;
        run_vector("sat", 1'b0);

        // All-zero weights: three-way tie resolves to index 0.
        for (int r = 0; r < 5; r++) rom[r] = '0;
        exp_out[0] = 16'h0000; exp_out[1] = 16'h0000; exp_out[2] = 16'h0000;
        exp_pred = 2'd0;
        chk_lat  = 1;
        run_vector("tie", 1'b1);
        chk_lat  = 0;

        // Output backpressure 1,0,0,1.
        load_test1();
        rdy_pat[1] = 1'b0;
        rdy_pat[2] = 1'b0;
        exp_out[0] = 16'h0100; exp_out[1] = 16'h0140; exp_out[2] = 16'hFF00;
        exp_pred = 2'd1;
        run_vector("bp", 1'b0);

        // Input gaps give identical results.
        load_test1();
        gap[0] = 2; gap[1] = 0; gap[2] = 3; gap[3] = 1;
        exp_out[2] = 16'h0000;
        run_vector("gaps", 1'b1);

        // Reset in the middle of MAC, then a clean run.
        load_test1();
        feed("mid_rst", 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        chk("mid_rst_busy_pre", 32'(busy), 32'd1);
        chk("mid_rst_w_rd_pre", 32'(w_rd), 32'd1);
        #1 Rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_w_rd", 32'(w_rd), 32'd0);
        chk("mid_rst_w_addr", 32'(w_addr), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pred", 32'(pred), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        exp_out[0] = 16'h0100; exp_out[1] = 16'h0140; exp_out[2] = 16'h0000;
        exp_pred = 2'd1;
        run_vector("post_rst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
- Parametrised fully-connected layer for the MNIST inference path; one instance per layer, chained in-to-out to form the network.
- Input vector is buffered, then MACs run over N_IN inputs with N_OUT parallel lanes; weights stream from an external row-wide ROM.
- Signed fixed point replaces float32. Adds optional ReLU, bias-row fetch, valid/ready handshakes and an in-stream argmax.

Parameters:
N_IN, 784, input vector length (>=1)
N_OUT, 30, output neurons = parallel MAC lanes (>=1)
DATA_W, 16, signed activation/weight width
FRAC, 8, fractional bits (Q(DATA_W-FRAC).FRAC)
ACC_W, 48, accumulator width; elaboration assertion ACC_W >= 2*DATA_W + clog2(N_IN+1)
AW, clog2(N_IN+1), weight ROM address width

Ports:
Clk  in  1  clock
Rst_n  in  1  reset, asynchronous, active-low
relu_en  in  1  apply ReLU; sampled on first input handshake of a run
in_valid  in  1  input word valid
in_ready  out  1  engine accepts input (IDLE/LOAD only)
in_data  in  DATA_W  signed input activation, element order 0..N_IN-1
w_rd  out  1  weight ROM read strobe
w_addr  out  AW  row address; rows 0..N_IN-1 weights, row N_IN biases
w_data  in  N_OUT*DATA_W  row data, lane j at [j*DATA_W +: DATA_W], valid 1 cycle after the w_rd edge
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  activation of neuron out_idx
out_idx  out  clog2(N_OUT)  neuron index of current beat
out_last  out  1  high on beat N_OUT-1
pred  out  clog2(N_OUT)  argmax index, held until next pred_valid
pred_valid  out  1  one-cycle pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1, all other outputs 0; counters, accumulators and input buffer cleared. A run in progress is discarded with no partial output.
- States: IDLE, LOAD, BIAS, MAC, ACT, OUT, DONE.
- IDLE: in_ready=1. A handshake stores word 0, latches relu_en, goes to LOAD (or BIAS if N_IN==1).
- LOAD: in_ready=1. Stores words by count; after word N_IN-1 goes to BIAS. Gaps in in_valid are allowed.
- BIAS: in_ready=0; w_rd=1, w_addr=N_IN; goes to MAC.
- MAC: issues rows 0..N_IN-1 on consecutive cycles, one read per cycle.
  - First returned beat (bias): acc_j <= sign_ext(b_j) << FRAC.
  - Each returned beat k: acc_j <= acc_j + x_k*w_kj (full 2*DATA_W signed product, sign-extended).
  - Leaves after the last beat is accumulated.
- ACT, one cycle: r_j = acc_j >>> FRAC. If relu_en and r_j<0, r_j=0. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register all N_OUT results.
- OUT: out_valid=1 with out_idx = beat counter. out_data/out_idx/out_last are held stable while out_ready=0. Advances on handshake. Argmax tracks beats as accepted; ties keep the lower index. After the handshake with out_last=1 goes to DONE.
- DONE: pred_valid=1 for one cycle, pred updated; goes to IDLE.
- Latency: last input handshake at cycle c → first out_valid at c+N_IN+4. With out_ready held high, pred_valid at c+N_IN+4+N_OUT.
- No overlap: a new input run is accepted only from IDLE. in_valid during busy is ignored (in_ready=0).
- Accumulator never wraps, given the ACC_W assertion.

Decomposition:
- Package nn_pkg holds: fc_state_t enum; the sat_fx function (shift, ReLU, saturate); DATA_W/FRAC defaults as localparams shared with other layers.
- Sub-module fc_mac_lane, generated N_OUT times: one accumulator with init/accumulate controls plus ACT logic, outputting the DATA_W result.
- Top holds the FSM, input buffer, address generator, output mux and argmax.

Test Plan:
- Basic, relu on (N_IN=4, N_OUT=3, relu_en=1): x=[0x0100,0x0200,0,0]; row0=[0x0100,0,0xFF00], row1=[0,0x0080,0], rows2-3=0, bias=[0,0x0040,0] -> out=[0x0100,0x0140,0x0000], pred=1.
- Same stimulus, relu_en=0 -> out=[0x0100,0x0140,0xFF00], pred=1.
- Saturation: x=4×0x7F00, all w=0x0100, bias0=0 -> 0x7FFF. Lane with w=0xFF00, relu off -> 0x8000.
- Tie and latency: all weights/bias 0 -> out all 0x0000, pred=0. First out_valid exactly N_IN+4 cycles after the last input handshake; w_addr sequence N_IN,0,1,2,3.
- Backpressure: out_ready toggling 1,0,0,1 -> each beat held stable with no loss or duplicates, out_last only on idx 2. Random in_valid gaps -> identical results.
- Reset mid-MAC: drop Rst_n in MAC cycle 2 -> all outputs 0 immediately, in_ready=1 after release. Next run produces correct outputs.
